// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stage enables, flushes, forwarding, memory-wait timeout.
// Optional stall counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [4:0]  IDrs,
   input  logic [4:0]  IDrt,
   input  logic        IDuseRs,
   input  logic        IDuseRt,
   input  logic [4:0]  EXrs,
   input  logic [4:0]  EXrt,
   input  logic        EXwreg,
   input  logic        EXm2reg,
   input  logic [4:0]  EXwn,
   input  logic        EXbranchTaken,
   input  logic        MEMwreg,
   input  logic [4:0]  MEMwn,
   input  logic        MEMreq,
   input  logic        MEMready,
   input  logic        WBwreg,
   input  logic [4:0]  WBwn,
   output logic        pcEn,
   output logic        IFIDen,
   output logic        IDEXen,
   output logic        EXMEMen,
   output logic        MEMWBen,
   output logic        IFIDflush,
   output logic        IDEXflush,
   output logic [1:0]  fwdA,
   output logic [1:0]  fwdB,
   output logic        memErr,
   output logic [31:0] stallCnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     state_q, state_d, cur_state;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;
   logic       load_use;
   logic       advance;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (MEMwreg && (MEMwn != 5'd0) && (MEMwn == src))
         return 2'b10;
      else if (WBwreg && (WBwn != 5'd0) && (WBwn == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwdA   = fwd_sel(EXrs);
   assign fwdB   = fwd_sel(EXrt);
   assign memErr = mem_err_q;

   assign load_use = EXm2reg && EXwreg && (EXwn != 5'd0) &&
                     ((IDuseRs && (EXwn == IDrs)) || (IDuseRt && (EXwn == IDrt)));

   always_comb begin
      // During the reset cycle the outputs behave as if already in RUN.
      cur_state  = clrn ? ST_RUN : state_q;
      state_d    = cur_state;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      advance    = 1'b0;
      pcEn       = 1'b0;
      IFIDen     = 1'b0;
      IDEXen     = 1'b0;
      EXMEMen    = 1'b0;
      MEMWBen    = 1'b0;
      IFIDflush  = 1'b0;
      IDEXflush  = 1'b0;

      case (cur_state)
         ST_RUN: begin
            if (MEMreq && !MEMready) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
            end else begin
               advance = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (MEMready) begin
               advance    = 1'b1;
               wait_cnt_d = 8'd0;
               state_d    = ST_RUN;
            end else if (wait_cnt_q == WAIT_MAX) begin
               mem_err_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase

      if (advance) begin
         pcEn    = 1'b1;
         IFIDen  = 1'b1;
         IDEXen  = 1'b1;
         EXMEMen = 1'b1;
         MEMWBen = 1'b1;
         if (EXbranchTaken) begin
            IFIDflush = 1'b1;
            IDEXflush = 1'b1;
         end else if (load_use) begin
            // One bubble: hold PC and IF/ID, squash the consumer entering EX.
            pcEn      = 1'b0;
            IFIDen    = 1'b0;
            IDEXflush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pcEn && (state_q != ST_HALT) && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (clrn)
         stall_cnt_q <= 32'd0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stallCnt = stall_cnt_q;
`else
   assign stallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (instance uses MEM_WAIT_MAX=4); expectations are hand-computed.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        clrn;
   logic [4:0]  IDrs, IDrt, EXrs, EXrt, EXwn, MEMwn, WBwn;
   logic        IDuseRs, IDuseRt, EXwreg, EXm2reg, EXbranchTaken;
   logic        MEMwreg, MEMreq, MEMready, WBwreg;
   logic        pcEn, IFIDen, IDEXen, EXMEMen, MEMWBen, IFIDflush, IDEXflush;
   logic [1:0]  fwdA, fwdB;
   logic        memErr;
   logic [31:0] stallCnt;

   int total = 0;
   int bad   = 0;
   int st    = 0;   // hand-tracked stall count

   pipe_ctrl #(.MEM_WAIT_MAX(4)) dut (
      .clk(clk), .clrn(clrn),
      .IDrs(IDrs), .IDrt(IDrt), .IDuseRs(IDuseRs), .IDuseRt(IDuseRt),
      .EXrs(EXrs), .EXrt(EXrt), .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwn(EXwn),
      .EXbranchTaken(EXbranchTaken),
      .MEMwreg(MEMwreg), .MEMwn(MEMwn), .MEMreq(MEMreq), .MEMready(MEMready),
      .WBwreg(WBwreg), .WBwn(WBwn),
      .pcEn(pcEn), .IFIDen(IFIDen), .IDEXen(IDEXen), .EXMEMen(EXMEMen), .MEMWBen(MEMWBen),
      .IFIDflush(IFIDflush), .IDEXflush(IDEXflush),
      .fwdA(fwdA), .fwdB(fwdB), .memErr(memErr), .stallCnt(stallCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] perf(input int n);
`ifdef PIPE_CTRL_PERF_EN
      return 32'(n);
`else
      return 32'd0 + 32'(n - n);
`endif
   endfunction

   task automatic idle();
      IDrs = 0; IDrt = 0; IDuseRs = 0; IDuseRt = 0;
      EXrs = 0; EXrt = 0; EXwreg = 0; EXm2reg = 0; EXwn = 0; EXbranchTaken = 0;
      MEMwreg = 0; MEMwn = 0; MEMreq = 0; MEMready = 0;
      WBwreg = 0; WBwn = 0;
   endtask

   task automatic step(input bit stalled);
      if (stalled) st++;
      @(posedge clk);
      #1;
   endtask

   task automatic check_en(input string tag, input logic [4:0] en, input logic [1:0] fl);
      #1;
      check({tag, "_en"}, 32'({pcEn, IFIDen, IDEXen, EXMEMen, MEMWBen}), 32'(en));
      check({tag, "_fl"}, 32'({IFIDflush, IDEXflush}), 32'(fl));
   endtask

   task automatic set_load_use();
      EXm2reg = 1; EXwreg = 1; EXwn = 5; IDrs = 5; IDuseRs = 1;
   endtask

   initial begin
      idle();
      clrn = 1;
      @(negedge clk);
      check_en("rst_cycle", 5'b11111, 2'b00);
      step(0);
      clrn = 0;
      check_en("rst_after", 5'b11111, 2'b00);
      check("rst_memerr", 32'(memErr), 32'd0);
      check("rst_stall", stallCnt, 32'd0);

      // load-use on rs
      set_load_use();
      check_en("lu", 5'b00111, 2'b01);
      step(1);
      idle();
      MEMwreg = 1; MEMwn = 5; EXrs = 5;
      check_en("lu_next", 5'b11111, 2'b00);
      check("lu_fwdA", 32'(fwdA), 32'b10);
      check("lu_stall", stallCnt, perf(st));

      // hazard boundaries: rt match without use, and r0 destination
      idle(); EXm2reg = 1; EXwreg = 1; EXwn = 6; IDrt = 6; IDuseRt = 0;
      check_en("lu_nouse", 5'b11111, 2'b00);
      IDuseRt = 1;
      check_en("lu_rt", 5'b00111, 2'b01);
      EXwn = 0; IDrt = 0;
      check_en("lu_r0", 5'b11111, 2'b00);

      // branch overrides load-use
      idle(); set_load_use(); EXbranchTaken = 1;
      check_en("br_lu", 5'b11111, 2'b11);
      step(0);

      // forwarding priority
      idle(); EXrs = 7; EXrt = 7; MEMwreg = 1; MEMwn = 7; WBwreg = 1; WBwn = 7;
      #1;
      check("fwd_mem", 32'(fwdA), 32'b10);
      check("fwdB_mem", 32'(fwdB), 32'b10);
      MEMwreg = 0;
      #1;
      check("fwd_wb", 32'(fwdA), 32'b01);
      EXrt = 3;
      #1;
      check("fwdB_none", 32'(fwdB), 32'b00);
      EXrs = 0; WBwn = 0; MEMwn = 0; MEMwreg = 1;
      #1;
      check("fwd_r0", 32'(fwdA), 32'b00);

      // ready in the same cycle: no stall
      idle(); MEMreq = 1; MEMready = 1;
      check_en("mem_zero", 5'b11111, 2'b00);
      step(0);

      // memory wait: 3 frozen cycles, then advance (with a taken branch)
      idle(); MEMreq = 1; EXbranchTaken = 1;
      check_en("mw1", 5'b00000, 2'b00);
      step(1);
      check_en("mw2", 5'b00000, 2'b00);
      step(1);
      check_en("mw3", 5'b00000, 2'b00);
      step(1);
      MEMready = 1;
      check_en("mw_rdy", 5'b11111, 2'b11);
      step(0);
      idle();
      check_en("mw_run", 5'b11111, 2'b00);
      check("mw_stall", stallCnt, perf(st));

      // timeout: one RUN freeze cycle plus four MEM_WAIT cycles
      MEMreq = 1;
      for (int i = 0; i < 4; i++) step(1);
      check("to_pre_err", 32'(memErr), 32'd0);
      check_en("to_pre", 5'b00000, 2'b00);
      step(1);
      check("to_err", 32'(memErr), 32'd1);
      MEMready = 1;
      check_en("halt", 5'b00000, 2'b00);
      check("halt_stall", stallCnt, perf(st));
      step(0); step(0);
      check("halt_hold", stallCnt, perf(st));
      check("halt_err", 32'(memErr), 32'd1);
      idle(); clrn = 1;
      check_en("halt_rst", 5'b11111, 2'b00);
      step(0);
      clrn = 0; st = 0;
      check("rst_err", 32'(memErr), 32'd0);
      check("rst_stall2", stallCnt, 32'd0);
      check_en("rst_run", 5'b11111, 2'b00);

      // reset mid-wait, then a full timeout must take five cycles again
      MEMreq = 1;
      step(1); step(1);
      idle(); clrn = 1;
      step(0);
      clrn = 0; st = 0;
      check_en("mid_rst", 5'b11111, 2'b00);
      MEMreq = 1;
      for (int i = 0; i < 4; i++) step(1);
      check("mid_pre_err", 32'(memErr), 32'd0);
      step(1);
      check("mid_err", 32'(memErr), 32'd1);
      check("mid_stall", stallCnt, perf(st));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
